// File: rtl/sync_fifo_param.sv
// Single-clock circular-buffer FIFO with any depth >= 2, occupancy count, thresholds and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through output; the default build has a registered 1-cycle read.
module sync_fifo_param #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int AF_LEVEL   = 6,
   parameter int AE_LEVEL   = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         w_en,
   input  logic [DATA_WIDTH-1:0]        data_in,
   input  logic                         r_en,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  rd_acc;
   logic                  wr_acc;

   // Pointers wrap by explicit compare so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign full         = (count == CNT_FULL);
   assign empty        = (count == '0);
   assign almost_full  = (count >= CNT_AF);
   assign almost_empty = (count <= CNT_AE);

   // Handshake: w_en/r_en are requests sampled every rising edge; a write is taken when
   // not full or when a read is taken in the same cycle, a read is taken when not empty.
   // A request that is not taken sets the matching sticky error flag.
   assign rd_acc = r_en & ~empty;
   assign wr_acc = w_en & (~full | rd_acc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (w_en && !wr_acc) overflow  <= 1'b1;
         if (r_en && !rd_acc) underflow <= 1'b1;
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_acc && !flush) mem[wr_ptr] <= data_in;
   end

`ifdef FIFO_FWFT_EN
   assign data_out = empty ? '0 : mem[rd_ptr];
`else
   logic [DATA_WIDTH-1:0] data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         data_q <= '0;
      else if (flush)  data_q <= '0;
      else if (rd_acc) data_q <= mem[rd_ptr];
   end

   assign data_out = data_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: default 8-deep instance and a 6-deep instance (AF=5, AE=1).
// Expected values come from hand-written constants plus a small queue model of the FIFO contents.
module tb_sync_fifo_param;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic       flush0, w_en0, r_en0;
   logic [7:0] din0, dout0;
   logic       full0, empty0, af0, ae0, ovf0, udf0;
   logic [3:0] count0;

   logic       flush1, w_en1, r_en1;
   logic [7:0] din1, dout1;
   logic       full1, empty1, af1, ae1, ovf1, udf1;
   logic [2:0] count1;

   sync_fifo_param u_dut0 (
      .clk(clk), .rst(rst), .flush(flush0), .w_en(w_en0), .data_in(din0), .r_en(r_en0),
      .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
      .count(count0), .overflow(ovf0), .underflow(udf0)
   );

   sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(6), .AF_LEVEL(5), .AE_LEVEL(1)) u_dut1 (
      .clk(clk), .rst(rst), .flush(flush1), .w_en(w_en1), .data_in(din1), .r_en(r_en1),
      .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
      .count(count1), .overflow(ovf1), .underflow(udf1)
   );

   // ---------------- scoreboard ----------------
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q[$];
   logic       ovf_m, udf_m;
   logic [7:0] dout_m;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      ovf_m  = 1'b0;
      udf_m  = 1'b0;
      dout_m = 8'h00;
   endtask

   task automatic check_outputs(input int sel, input string tag);
      int         depth, af_lvl, ae_lvl, sz;
      logic [3:0] c;
      logic [7:0] d, exp_d;
      logic       f, e, af, ae, ov, ud;
      depth  = (sel == 0) ? 8 : 6;
      af_lvl = (sel == 0) ? 6 : 5;
      ae_lvl = (sel == 0) ? 2 : 1;
      if (sel == 0) begin
         c = count0; d = dout0; f = full0; e = empty0; af = af0; ae = ae0; ov = ovf0; ud = udf0;
      end else begin
         c = {1'b0, count1}; d = dout1; f = full1; e = empty1; af = af1; ae = ae1; ov = ovf1; ud = udf1;
      end
      sz = exp_q.size();
`ifdef FIFO_FWFT_EN
      exp_d = (sz != 0) ? exp_q[0] : 8'h00;
`else
      exp_d = dout_m;
`endif
      check({tag, ".count"},     32'(c),  32'(sz));
      check({tag, ".full"},      32'(f),  32'(sz == depth));
      check({tag, ".empty"},     32'(e),  32'(sz == 0));
      check({tag, ".a_full"},    32'(af), 32'(sz >= af_lvl));
      check({tag, ".a_empty"},   32'(ae), 32'(sz <= ae_lvl));
      check({tag, ".overflow"},  32'(ov), 32'(ovf_m));
      check({tag, ".underflow"}, 32'(ud), 32'(udf_m));
      check({tag, ".data_out"},  32'(d),  32'(exp_d));
   endtask

   // ---------------- driver ----------------
   task automatic step(input int sel, input logic w, input logic [7:0] d, input logic r, input string tag);
      int   depth, sz;
      logic rd, wr;
      depth = (sel == 0) ? 8 : 6;
      sz    = exp_q.size();
      rd    = r && (sz != 0);
      wr    = w && ((sz < depth) || rd);
      if (w && !wr) ovf_m = 1'b1;
      if (r && !rd) udf_m = 1'b1;
      if (rd) dout_m = exp_q.pop_front();
      if (wr) exp_q.push_back(d);
      if (sel == 0) begin w_en0 = w; din0 = d; r_en0 = r; end
      else          begin w_en1 = w; din1 = d; r_en1 = r; end
      @(posedge clk);
      #1;
      w_en0 = 1'b0; r_en0 = 1'b0; w_en1 = 1'b0; r_en1 = 1'b0;
      check_outputs(sel, tag);
   endtask

   task automatic do_flush(input int sel, input string tag);
      if (sel == 0) begin flush0 = 1'b1; w_en0 = 1'b1; din0 = 8'h77; end
      else          begin flush1 = 1'b1; w_en1 = 1'b1; din1 = 8'h77; end
      @(posedge clk);
      #1;
      flush0 = 1'b0; flush1 = 1'b0; w_en0 = 1'b0; w_en1 = 1'b0;
      model_clear();
      check_outputs(sel, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] dv;
      rst = 1'b0;
      flush0 = 1'b0; w_en0 = 1'b0; r_en0 = 1'b0; din0 = 8'h00;
      flush1 = 1'b0; w_en1 = 1'b0; r_en1 = 1'b0; din1 = 8'h00;
      model_clear();
      #1 rst = 1'b1;
      #1;
      check("reset.count",    32'(count0), 32'd0);
      check("reset.empty",    32'(empty0), 32'd1);
      check("reset.full",     32'(full0),  32'd0);
      check("reset.a_empty",  32'(ae0),    32'd1);
      check("reset.a_full",   32'(af0),    32'd0);
      check("reset.data_out", 32'(dout0),  32'h00);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_outputs(0, "reset0");
      check_outputs(1, "reset1");

      // Fill to full, then one rejected write.
      for (int i = 0; i < 8; i++) step(0, 1'b1, 8'(8'h11 + i), 1'b0, "fill");
      check("fill.count_8", 32'(count0), 32'd8);
      check("fill.full_8",  32'(full0),  32'd1);
      step(0, 1'b1, 8'h99, 1'b0, "over");
      check("over.flag",  32'(ovf0),   32'd1);
      check("over.count", 32'(count0), 32'd8);

      // Drain, then one rejected read.
      for (int i = 0; i < 8; i++) step(0, 1'b0, 8'h00, 1'b1, "drain");
`ifndef FIFO_FWFT_EN
      check("drain.last_word", 32'(dout0), 32'h18);
`endif
      step(0, 1'b0, 8'h00, 1'b1, "under");
      check("under.flag", 32'(udf0), 32'd1);
`ifdef FIFO_FWFT_EN
      check("under.data_out", 32'(dout0), 32'h00);
`else
      check("under.data_hold", 32'(dout0), 32'h18);
`endif

      // Flush with count=3 and overflow still set; concurrent write must be dropped.
      for (int i = 0; i < 3; i++) step(0, 1'b1, 8'(8'h31 + i), 1'b0, "pre_flush");
      check("pre_flush.count", 32'(count0), 32'd3);
      do_flush(0, "flush");
      check("flush.overflow", 32'(ovf0),   32'd0);
      check("flush.count",    32'(count0), 32'd0);

      // Full FIFO with simultaneous read+write, then drain across the wrap.
      for (int i = 0; i < 8; i++) step(0, 1'b1, 8'(8'h21 + i), 1'b0, "refill");
      for (int i = 0; i < 4; i++) step(0, 1'b1, 8'(8'hA0 + i), 1'b1, "rw_full");
      check("rw_full.count", 32'(count0), 32'd8);
      for (int i = 0; i < 8; i++) step(0, 1'b0, 8'h00, 1'b1, "wrap_drain");
`ifndef FIFO_FWFT_EN
      check("wrap_drain.last", 32'(dout0), 32'hA3);
`endif

      // Empty with both requests: write taken, read rejected.
      step(0, 1'b1, 8'h5A, 1'b1, "empty_rw");
      check("empty_rw.count",     32'(count0), 32'd1);
      check("empty_rw.underflow", 32'(udf0),   32'd1);
      step(0, 1'b0, 8'h00, 1'b0, "idle");
`ifdef FIFO_FWFT_EN
      check("fwft.show", 32'(dout0), 32'h5A);
`endif
      step(0, 1'b0, 8'h00, 1'b1, "pop");
      check("pop.empty", 32'(empty0), 32'd1);

      // Asynchronous reset between edges during a write burst.
      for (int i = 0; i < 3; i++) step(0, 1'b1, 8'(8'hC0 + i), 1'b0, "burst");
      step(0, 1'b0, 8'h00, 1'b1, "burst_rd");
      w_en0 = 1'b1; din0 = 8'hCF;
      #2 rst = 1'b1;
      #1;
      check("async_rst.count",     32'(count0), 32'd0);
      check("async_rst.empty",     32'(empty0), 32'd1);
      check("async_rst.data_out",  32'(dout0),  32'h00);
      check("async_rst.underflow", 32'(udf0),   32'd0);
      w_en0 = 1'b0;
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      check_outputs(0, "post_rst");
      step(0, 1'b1, 8'h42, 1'b0, "post_rst_wr");
      check("post_rst_wr.count", 32'(count0), 32'd1);

      // DEPTH=6 instance: 20 alternating write/read bursts through the wrap.
      model_clear();
      dv = 8'h01;
      for (int b = 0; b < 20; b++) begin
         if (b % 2 == 0) begin
            for (int k = 0; k < 1 + (b * 3) % 5; k++) begin
               step(1, 1'b1, dv, 1'b0, "d6_wr");
               dv = dv + 8'h01;
            end
         end else begin
            for (int k = 0; k < 1 + (b * 2) % 5; k++) step(1, 1'b0, 8'h00, 1'b1, "d6_rd");
         end
      end
      for (int k = 0; k < 7; k++) step(1, 1'b0, 8'h00, 1'b1, "d6_final");
      check("d6.empty", 32'(empty1), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised successor to the team's pointer-based synchronous FIFO.
- Single-clock circular buffer with:
  - configurable data width and any depth ≥ 2 (not restricted to powers of two)
  - occupancy count and programmable almost-full/almost-empty thresholds
  - sticky overflow/underflow error flags and a synchronous flush
- Sits between producer and consumer blocks in the same clock domain.

Parameters:
- DATA_WIDTH, 8, bits per word
- DEPTH, 8, number of storage words; must be ≥ 2
- AF_LEVEL, 6, almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL; range 0..DEPTH-1

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of all contents and flags
- w_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- r_en  in  1  read request
- data_out  out  DATA_WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  $clog2(DEPTH+1)  current occupancy
- overflow  out  1  sticky: write rejected
- underflow  out  1  sticky: read rejected

Behaviour:
- Reset (rst=1, async): wr_ptr=0, rd_ptr=0, count=0, data_out=0, overflow=0, underflow=0.
  - Flags then: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), i.e. 0 for legal AF_LEVEL.
  - Storage array is not reset.
- Pointers: range 0..DEPTH-1; increment wraps from DEPTH-1 to 0 (explicit compare, not modulo-2^n).
- Read acceptance: rd_acc = r_en & ~empty.
- Write acceptance: wr_acc = w_en & (~full | rd_acc).
  - Full with simultaneous read: both are accepted; count stays DEPTH.
- Empty with both requests: the write is accepted and the read is rejected.
  - underflow sets; count goes to 1.
- count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
- Flags:
  - full, empty, almost_full and almost_empty are decoded combinationally from the registered count.
  - They are valid in the cycle after the edge that changed count.
- Standard read timing (macro undefined):
  - On rd_acc, data_out <= mem[rd_ptr] at that edge.
  - Latency is 1 cycle from the r_en sample edge; data_out holds its value otherwise.
- Write: on wr_acc, mem[wr_ptr] <= data_in.
- Errors:
  - overflow <= 1 when w_en & ~wr_acc.
  - underflow <= 1 when r_en & ~rd_acc.
  - Both are sticky until rst or flush.
- Flush (priority below rst, above all else):
  - Pointers, count, overflow, underflow and data_out are cleared to 0 on the edge.
  - w_en and r_en are ignored that cycle.
- Reset mid-operation: immediate async clear; the FIFO is empty on the first edge after deassertion.

Optional Feature:
- Macro FIFO_FWFT_EN: first-word-fall-through mode.
- Defined:
  - data_out = mem[rd_ptr] combinationally whenever empty=0; data_out = 0 when empty=1.
  - r_en acts as pop/acknowledge of the displayed word.
  - All acceptance, count and flag rules are unchanged.
- Undefined: registered 1-cycle read latency as described under Behaviour.

Test Plan:
- Reset, then write 0x11..0x18 on 8 consecutive cycles (DEPTH=8):
  - count=8, full=1, almost_full=1 from count=6.
  - 9th write 0x99 is rejected: overflow=1, count stays 8.
- Read 8 words:
  - data_out sequence is 0x11..0x18, one cycle after each r_en.
  - empty=1 and almost_empty=1 once count≤2.
  - 9th read: underflow=1, data_out holds 0x18.
- Full FIFO with w_en=r_en=1 for 4 cycles writing 0xA0..0xA3:
  - count stays 8, oldest 4 words are popped.
  - Subsequent drain returns the remaining 4 old words, then 0xA0..0xA3.
  - Exercises pointer wrap.
- DEPTH=6, AF_LEVEL=5, AE_LEVEL=1: 20 alternating write/read bursts.
  - Pointers wrap at 5→0, data order is preserved, flags match count at every cycle.
- Flush with count=3 and overflow=1:
  - Next cycle count=0, empty=1, overflow=0, data_out=0.
  - Concurrent w_en is ignored.
- Assert rst mid-burst between clock edges:
  - Outputs clear immediately without waiting for an edge.
- FIFO_FWFT_EN defined, write 0x5A:
  - data_out=0x5A in the cycle after the write with no r_en.
  - After r_en: empty=1, data_out=0.
